// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter
//   Round-robin burst arbiter for a shared, key-selected output mux. One requester
//   at a time is granted and keeps the grant until it delivers a beat flagged as
//   last. The registered grant index drives the mux key and the handshake steering.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester beat valid
//   req_last   per-requester last-beat flag (qualified by req_valid)
//   req_data   packed requester data, requester n at [DATA_LEN*(n+1)-1 : DATA_LEN*n]
//   req_ready  per-requester beat accepted
//   out_valid  downstream beat valid
//   out_last   downstream last flag
//   out_data   downstream data (granted requester's data)
//   out_ready  downstream accept
//   out_sel    current grant index / mux key
//   busy       high while a grant is held
module rr_burst_arbiter #(
    parameter int NR_REQ   = 4,
    parameter int SEL_W    = 2,
    parameter int DATA_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NR_REQ-1:0]          req_valid,
    input  logic [NR_REQ-1:0]          req_last,
    input  logic [NR_REQ*DATA_LEN-1:0] req_data,
    output logic [NR_REQ-1:0]          req_ready,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [DATA_LEN-1:0]        out_data,
    input  logic                       out_ready,
    output logic [SEL_W-1:0]           out_sel,
    output logic                       busy
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state;
    logic [SEL_W-1:0] rr_ptr;
    logic             found;
    logic [SEL_W-1:0] pick;
    logic             lock;
    logic             beat;
    logic [SEL_W-1:0] next_ptr;

    assign lock = (state == LOCK);

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NR_REQ (not at 2**SEL_W), so indices
    // beyond the last requester are never produced.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NR_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NR_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = SEL_W'(idx);
            end
        end
    end

    // Datapath and handshake steering come straight off the registered grant.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        req_ready = '0;
        if (lock) begin
            out_valid          = req_valid[out_sel];
            out_last           = req_last[out_sel];
            out_data           = req_data[int'(out_sel)*DATA_LEN +: DATA_LEN];
            req_ready[out_sel] = out_ready;
        end
    end

    assign beat     = out_valid & out_ready;
    assign next_ptr = (out_sel == SEL_W'(NR_REQ - 1)) ? '0 : out_sel + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out_sel <= '0;
            rr_ptr  <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        out_sel <= pick;
                        state   <= LOCK;
                        busy    <= 1'b1;
                    end
                end
                LOCK: begin
                    // Only a completed last beat releases; a dropped valid holds the lock.
                    if (beat && out_last) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
